// File: rtl/seq_signed_multiplier.sv
// Sequential shift-add signed multiplier with start/busy/done handshake.
// Multiplies operand magnitudes, then applies the sign in a final cycle.
module seq_signed_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               product_neg,
   output logic [2*WIDTH-1:0] product_mag
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SIGN
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic            sign_q, sign_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   product_q, product_d;
   logic            neg_q, neg_d;
   logic [PW-1:0]   mag_q, mag_d;
   logic            done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         sign_q    <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
         neg_q     <= 1'b0;
         mag_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         sign_q    <= sign_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         neg_q     <= neg_d;
         mag_q     <= mag_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      sign_d    = sign_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      neg_d     = neg_q;
      mag_d     = mag_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
               mcand_d  = a[WIDTH-1] ? -a : a;
               mplier_d = b[WIDTH-1] ? -b : b;
               sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (mplier_q[cnt_q])
               acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1))
               state_d = SIGN;
         end
         SIGN: begin
            product_d = sign_q ? -acc_q : acc_q;
            mag_d     = acc_q;
            neg_d     = sign_q & (|acc_q);
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign product     = product_q;
   assign product_neg = neg_q;
   assign product_mag = mag_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench for seq_signed_multiplier: directed vectors,
// expected results queued at issue, checked by a done-driven monitor.
module tb_seq_signed_multiplier;

   localparam int W = 8;

   typedef struct {
      logic [2*W-1:0] p;
      logic           n;
      logic [2*W-1:0] m;
      int             t;
   } exp_t;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic           product_neg;
   logic [2*W-1:0] product_mag;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   busy_len = 0;
   exp_t sb[$];

   seq_signed_multiplier #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .product     (product),
      .product_neg (product_neg),
      .product_mag (product_mag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: pop and compare on every done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done) begin
            chk("done_busy_low", busy, 0);
            chk("busy_len", busy_len, W + 1);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
               e = sb.pop_front();
               chk("product", product, e.p);
               chk("product_neg", product_neg, e.n);
               chk("product_mag", product_mag, e.m);
               chk("latency", cyc - e.t, W + 1);
            end
         end
         busy_len = busy ? busy_len + 1 : 0;
      end else begin
         busy_len = 0;
      end
   end

   task automatic push_exp(input int v);
      exp_t e;
      e.p = 16'(v);
      e.n = (v < 0);
      e.m = (v < 0) ? 16'(-v) : 16'(v);
      e.t = cyc + 1;
      sb.push_back(e);
   endtask

   // Called at a negedge; start is sampled on the following posedge
   task automatic issue(input int av, input int bv, input int expv);
      a     = 8'(av);
      b     = 8'(bv);
      start = 1'b1;
      push_exp(expv);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_product", product, 0);
      chk("rst_neg", product_neg, 0);
      chk("rst_mag", product_mag, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(7, -3, -21);
      wait_done("t1");
      @(negedge clk);
      issue(-128, -128, 16384);
      wait_done("t2a");
      @(negedge clk);
      issue(-128, 127, -16256);
      wait_done("t2b");
      @(negedge clk);
      issue(0, -5, 0);
      wait_done("t3a");
      @(negedge clk);
      issue(127, 127, 16129);
      wait_done("t3b");
      @(negedge clk);
      issue(-1, -1, 1);
      wait_done("t3c");
      @(negedge clk);

      // Start while busy is dropped; start in the done cycle is taken
      issue(10, -2, -20);
      @(negedge clk);
      @(negedge clk);
      a     = 8'd5;
      b     = 8'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t4a");
      issue(-3, -4, 12);
      wait_done("t4b");
      @(negedge clk);

      // Operand changes during RUN must not affect the result
      issue(6, -7, -42);
      a = 8'd100;
      b = 8'd100;
      @(negedge clk);
      a = 8'd3;
      b = 8'h80;
      wait_done("t5");
      @(negedge clk);

      // Reset mid-run aborts with no done pulse
      a     = 8'd9;
      b     = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_product", product, 0);
      chk("abort_neg", product_neg, 0);
      chk("abort_mag", product_mag, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_sb_empty", sb.size(), 0);
      issue(-1, 1, -1);
      wait_done("t6");
      repeat (3) @(negedge clk);
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
